// File: rtl/pc_unit.sv
// Program counter unit: BOOT/RUN/HALT sequencing, redirect and trap loading, fetch counting.
// Every output comes straight from a register, so no input reaches pc or pc_valid combinationally.
module pc_unit #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = 32'h01000000,
    parameter int                INC          = 4,
    parameter int                CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_ready,
    input  logic              redirect,
    input  logic [XLEN-1:0]   redirect_target,
    input  logic              trap_req,
    input  logic [XLEN-1:0]   trap_vector,
    input  logic              halt_req,
    output logic [XLEN-1:0]   pc,
    output logic              pc_valid,
    output logic              halted,
    output logic              misalign_err,
    output logic [XLEN-1:0]   err_addr,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic               misalign_q, misalign_d;
    logic [XLEN-1:0]    err_addr_q, err_addr_d;
    logic [CNT_W-1:0]   fetch_count_q, fetch_count_d;

    logic               accept;
    logic [XLEN-1:0]    redirect_t;
    logic [XLEN-1:0]    trap_t;

    assign accept     = (state_q == RUN) && fetch_ready;
    assign redirect_t = {redirect_target[XLEN-1:1], 1'b0};
    assign trap_t     = {trap_vector[XLEN-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misalign_d    = 1'b0;
        err_addr_d    = err_addr_q;
        fetch_count_d = fetch_count_q;

        // Counted even when a higher-priority event overrides the pc update.
        if (accept && (fetch_count_q != {CNT_W{1'b1}})) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
        end

        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (trap_req) begin
                    pc_d = trap_t;
                end else if (redirect) begin
                    if (redirect_t[1]) begin
                        err_addr_d = redirect_t;
                        misalign_d = 1'b1;
                        state_d    = HALT;
                    end else begin
                        pc_d = redirect_t;
                    end
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (fetch_ready) begin
                    pc_d = pc_q + XLEN'(INC);
                end
            end
            HALT: begin
                if (trap_req) begin
                    pc_d    = trap_t;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= BOOT;
            pc_q          <= RESET_VECTOR;
            misalign_q    <= 1'b0;
            err_addr_q    <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            misalign_q    <= misalign_d;
            err_addr_q    <= err_addr_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = (state_q == RUN);
    assign halted       = (state_q == HALT);
    assign misalign_err = misalign_q;
    assign err_addr     = err_addr_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed plus randomized scoreboard bench for pc_unit; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_pc_unit;

    localparam logic [31:0] RV = 32'h01000000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        trap_req = 1'b0;
    logic [31:0] trap_vector = '0;
    logic        halt_req = 1'b0;

    logic [31:0] pc, err_addr;
    logic        pc_valid, halted, misalign_err;
    logic [15:0] fetch_count;

    logic [31:0] pc2, err_addr2;
    logic        pc_valid2, halted2, misalign_err2;
    logic [1:0]  fetch_count2;

    always #5 clock = ~clock;

    pc_unit u_dut (
        .clock(clock), .reset(reset), .fetch_ready(fetch_ready),
        .redirect(redirect), .redirect_target(redirect_target),
        .trap_req(trap_req), .trap_vector(trap_vector), .halt_req(halt_req),
        .pc(pc), .pc_valid(pc_valid), .halted(halted),
        .misalign_err(misalign_err), .err_addr(err_addr), .fetch_count(fetch_count)
    );

    pc_unit #(.CNT_W(2)) u_dut2 (
        .clock(clock), .reset(reset), .fetch_ready(fetch_ready),
        .redirect(redirect), .redirect_target(redirect_target),
        .trap_req(trap_req), .trap_vector(trap_vector), .halt_req(halt_req),
        .pc(pc2), .pc_valid(pc_valid2), .halted(halted2),
        .misalign_err(misalign_err2), .err_addr(err_addr2), .fetch_count(fetch_count2)
    );

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        valid;
        logic        halted;
        logic        mis;
        logic [31:0] err;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference behaviour: 0 = BOOT, 1 = RUN, 2 = HALT
    int          m_state = 0;
    logic [31:0] m_pc = RV;
    logic        m_mis = 1'b0;
    logic [31:0] m_err = '0;
    int          m_cnt = 0;
    int          m_cnt2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input bit rst, input bit fr, input bit rd,
                        input logic [31:0] rt, input bit tr, input logic [31:0] tv,
                        input bit hr);
        exp_t e;
        exp_t o;
        logic [31:0] t;
        bit acc;
        @(negedge clock);
        reset = rst; fetch_ready = fr; redirect = rd; redirect_target = rt;
        trap_req = tr; trap_vector = tv; halt_req = hr;

        if (rst) begin
            m_state = 0; m_pc = RV; m_mis = 1'b0; m_err = '0; m_cnt = 0; m_cnt2 = 0;
        end else begin
            m_mis = 1'b0;
            acc = (m_state == 1) && fr;
            if (acc) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (m_state == 0) begin
                m_state = 1;
            end else if (m_state == 1) begin
                t = rt & 32'hFFFF_FFFE;
                if (tr) m_pc = tv & 32'hFFFF_FFFC;
                else if (rd) begin
                    if (t[1]) begin m_err = t; m_mis = 1'b1; m_state = 2; end
                    else m_pc = t;
                end
                else if (hr) m_state = 2;
                else if (acc) m_pc = m_pc + 32'd4;
            end else if (tr) begin
                m_pc = tv & 32'hFFFF_FFFC;
                m_state = 1;
            end
        end
        e.tag = tag; e.pc = m_pc; e.valid = (m_state == 1); e.halted = (m_state == 2);
        e.mis = m_mis; e.err = m_err; e.cnt = 16'(m_cnt); e.cnt2 = 2'(m_cnt2);
        sb.push_back(e);

        @(posedge clock);
        #1;
        o = sb.pop_front();
        $display("step %-10s rst=%0d fr=%0d rd=%0d tr=%0d hr=%0d -> pc=%h v=%0d h=%0d mis=%0d err=%h cnt=%0d cnt2=%0d",
                 o.tag, rst, fr, rd, tr, hr, pc, pc_valid, halted, misalign_err, err_addr, fetch_count, fetch_count2);
        chk({o.tag, ".pc"}, pc, o.pc);
        chk({o.tag, ".valid"}, 32'(pc_valid), 32'(o.valid));
        chk({o.tag, ".halted"}, 32'(halted), 32'(o.halted));
        chk({o.tag, ".mis"}, 32'(misalign_err), 32'(o.mis));
        chk({o.tag, ".err"}, err_addr, o.err);
        chk({o.tag, ".cnt"}, 32'(fetch_count), 32'(o.cnt));
        chk({o.tag, ".cnt2"}, 32'(fetch_count2), 32'(o.cnt2));
    endtask

    initial begin
        // Reset and sequential fetch
        step("rst0", 1, 1, 0, 0, 0, 0, 0);
        step("rst1", 1, 1, 0, 0, 0, 0, 0);
        chk("reset.pc", pc, RV);
        chk("reset.valid", 32'(pc_valid), 32'd0);
        step("boot", 0, 1, 0, 0, 0, 0, 0);
        chk("boot.pc", pc, RV);
        for (int i = 0; i < 5; i++) step("seq", 0, 1, 0, 0, 0, 0, 0);
        chk("seq.pc", pc, 32'h01000014);
        chk("seq.cnt", 32'(fetch_count), 32'd5);
        chk("sat.cnt2", 32'(fetch_count2), 32'd3);

        // Stall, then misaligned redirect
        step("stall", 0, 0, 0, 0, 0, 0, 0);
        step("stall", 0, 0, 0, 0, 0, 0, 0);
        step("mis_rd", 0, 0, 1, 32'h01000123, 0, 0, 0);
        chk("mis.err", err_addr, 32'h01000122);
        chk("mis.pulse", 32'(misalign_err), 32'd1);
        chk("mis.pc", pc, 32'h01000014);
        step("halt_rd", 0, 1, 1, 32'h00000040, 0, 0, 1);
        chk("mis.pulse_end", 32'(misalign_err), 32'd0);
        chk("halt.hold", 32'(halted), 32'd1);

        // Exit HALT by trap, then aligned redirect
        step("trap_h", 0, 1, 0, 0, 1, 32'h01000100, 0);
        chk("trap_h.valid", 32'(pc_valid), 32'd1);
        step("rd_ok", 0, 0, 1, 32'h01000101, 0, 0, 0);
        chk("rd_ok.pc", pc, 32'h01000100);
        step("trap_rd", 0, 1, 1, 32'h00000300, 1, 32'h00000207, 0);
        chk("trap_rd.pc", pc, 32'h00000204);

        // Address wrap
        step("trap_top", 0, 0, 0, 0, 1, 32'hFFFFFFFC, 0);
        step("wrap", 0, 1, 0, 0, 0, 0, 0);
        chk("wrap.pc", pc, 32'h00000000);
        chk("wrap.mis", 32'(misalign_err), 32'd0);
        step("seq2", 0, 1, 0, 0, 0, 0, 0);

        // halt_req with accepted fetch: counted, pc held
        step("halt_acc", 0, 1, 0, 0, 0, 0, 1);
        step("halt_idle", 0, 1, 0, 0, 0, 0, 0);
        step("trap_back", 0, 0, 0, 0, 1, 32'h00001000, 0);

        // halt during stall, then reset in HALT
        step("stall3", 0, 0, 0, 0, 0, 0, 0);
        step("halt_st", 0, 0, 0, 0, 0, 0, 1);
        chk("halt_st.pc", pc, 32'h00001000);
        step("rst_halt", 1, 1, 1, 32'h22, 1, 32'h44, 1);
        chk("rst_halt.pc", pc, RV);
        chk("rst_halt.halted", 32'(halted), 32'd0);
        chk("rst_halt.cnt", 32'(fetch_count), 32'd0);
        step("boot2", 0, 1, 1, 32'h00000080, 1, 32'h00000090, 1);
        step("run2", 0, 0, 0, 0, 0, 0, 0);
        // reset mid-redirect
        step("rst_rd", 1, 1, 1, 32'h00000082, 0, 0, 0);
        step("boot3", 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            step("rand", ($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0), $urandom(),
                 ($urandom_range(0, 11) == 0), $urandom(),
                 ($urandom_range(0, 14) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h01000000, first fetch address after reset.
REQ-003 SHALL have parameter INC, default 4, sequential increment in bytes.
REQ-004 SHALL have parameter CNT_W, default 16, width of the fetch counter.
REQ-005 SHALL have port clock, input, 1, the only clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port fetch_ready, input, 1, fetch stage accepts the current pc this cycle.
REQ-008 SHALL have port redirect, input, 1, jump/branch taken request.
REQ-009 SHALL have port redirect_target, input, XLEN, jump/branch target (ALU result).
REQ-010 SHALL have port trap_req, input, 1, trap request.
REQ-011 SHALL have port trap_vector, input, XLEN, trap handler address.
REQ-012 SHALL have port halt_req, input, 1, request to stop fetching.
REQ-013 SHALL have port pc, output, XLEN, current fetch address (registered).
REQ-014 SHALL have port pc_valid, output, 1, pc is a valid fetch request.
REQ-015 SHALL have port halted, output, 1, unit is in HALT.
REQ-016 SHALL have port misalign_err, output, 1, one-cycle pulse on misaligned redirect.
REQ-017 SHALL have port err_addr, output, XLEN, last offending redirect address (masked).
REQ-018 SHALL have port fetch_count, output, CNT_W, number of accepted fetches.

Function
REQ-019 SHALL implement states BOOT, RUN, HALT; pc_valid=1 only in RUN; halted=1 only in HALT.
REQ-020 BOOT SHALL last exactly one cycle, then RUN, with pc unchanged (= RESET_VECTOR).
REQ-021 A fetch is accepted in a cycle where pc_valid=1 and fetch_ready=1.
REQ-022 In RUN, per-cycle priority SHALL be: trap_req > redirect > halt_req > accepted fetch > hold.
REQ-023 trap_req (in RUN or HALT) SHALL load pc <= trap_vector with bits [1:0] cleared and go/stay RUN; BOOT ignores trap_req.
REQ-024 redirect in RUN SHALL compute t = redirect_target with bit 0 cleared.
REQ-025 If t[1]=0, pc SHALL load t next cycle; state stays RUN.
REQ-026 If t[1]=1, pc SHALL hold, err_addr SHALL load t, misalign_err SHALL be 1 for exactly the next cycle, state SHALL go HALT.
REQ-027 halt_req in RUN (no trap/redirect) SHALL go HALT with pc held; an accepted fetch that cycle is counted but pc not incremented.
REQ-028 Accepted fetch with no higher-priority event SHALL set pc <= pc + INC, modulo 2^XLEN (wraps to 0, no flag).
REQ-029 pc_valid=1 and fetch_ready=0 with no event SHALL hold pc (stall).
REQ-030 redirect and halt_req SHALL be ignored in BOOT and HALT; HALT exits only via trap_req or reset.
REQ-031 fetch_count SHALL increment by 1 per accepted fetch and saturate at 2^CNT_W-1.
REQ-032 Every redirect/trap target SHALL take effect one cycle after assertion; no combinational path from inputs to pc or pc_valid.

Reset
REQ-033 With reset=1 at a rising edge, regardless of state or other inputs: state=BOOT, pc=RESET_VECTOR, pc_valid=0, halted=0, misalign_err=0, err_addr=0, fetch_count=0.
REQ-034 Reset mid-stall, mid-redirect or in HALT SHALL discard the pending event entirely.

Verification
REQ-035 Reset, fetch_ready=1 continuously -> cycle 1 pc=0x01000000 valid=0; cycles 2,3,4 pc=0x01000000, 0x01000004, 0x01000008 valid=1; fetch_count counts 1,2,3.
REQ-036 redirect=1, target=0x01000123 with fetch_ready=0 -> next pc=0x01000122? no: bit1 set -> misalign_err pulse, err_addr=0x01000122, halted=1, pc held; target 0x01000101 -> pc=0x01000100, RUN.
REQ-037 trap_req and redirect same cycle, trap_vector=0x00000207 -> pc=0x00000204, redirect dropped; from HALT, trap_req -> RUN, pc_valid=1 next cycle.
REQ-038 XLEN=32, pc=0xFFFFFFFC, accepted fetch -> pc=0x00000000, no error; CNT_W=2 after 5 accepts -> fetch_count=3.
REQ-039 halt_req during fetch_ready=0 stall, then reset asserted in HALT -> HALT with pc held, then BOOT, pc=RESET_VECTOR, all counters/flags 0.
